// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit hex 7-segment driver: divides clk down to a per-digit hold
// time, steps a digit index, decodes the selected nibble and drives registered
// seg/dp/an outputs with selectable polarity, blanking and leading-zero suppression.
module seven_seg_scan #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLK_DIV        = 100000,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          ACTIVE_LOW_AN  = 1'b1,
  parameter bit          LZ_SUPPRESS    = 1'b0,
  localparam int unsigned IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DivMax = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IdxMax = IDX_W'(NUM_DIGITS - 1);

  // Inactive output levels, also the reset values.
  localparam logic [6:0]            SegOff = {7{ACTIVE_LOW_SEG}};
  localparam logic                  DpOff  = ACTIVE_LOW_SEG;
  localparam logic [NUM_DIGITS-1:0] AnOff  = {NUM_DIGITS{ACTIVE_LOW_AN}};

  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tick_q, tick_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  step;
  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  blank_sel;
  logic                  lz_sel;
  logic                  zero_run;
  logic                  dark;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [NUM_DIGITS-1:0] an_lit;
  logic [6:0]            seg_lit;
  logic                  dp_lit;

  // Lit-high segment pattern {a,b,c,d,e,f,g} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Divider and digit index; both freeze while en is low.
  always_comb begin
    step   = en && (div_q == DivMax);
    div_d  = div_q;
    idx_d  = idx_q;
    if (en) begin
      div_d = step ? '0 : div_q + DIV_W'(1);
    end
    if (step) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IDX_W'(1);
    end
    tick_d = step && (idx_q == IdxMax);
  end

  // Select the current digit and decide whether it is lit.
  always_comb begin
    nib        = '0;
    dp_sel     = 1'b0;
    blank_sel  = 1'b0;
    lz_sel     = 1'b0;
    an_lit     = '0;
    upper_zero = '0;
    zero_run   = 1'b1;
    // upper_zero[i]: nibbles i..NUM_DIGITS-1 are all zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (value[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        nib       = value[4*i +: 4];
        dp_sel    = dp_in[i];
        blank_sel = blank[i];
        lz_sel    = upper_zero[i] && (i > 0);
        an_lit[i] = 1'b1;
      end
    end
    dark    = !en || blank_sel || (LZ_SUPPRESS && lz_sel);
    seg_lit = dark ? 7'h00 : hex_to_seg(nib);
    dp_lit  = dark ? 1'b0 : dp_sel;
    if (dark) begin
      an_lit = '0;
    end
    seg_d = ACTIVE_LOW_SEG ? ~seg_lit : seg_lit;
    dp_d  = ACTIVE_LOW_SEG ? ~dp_lit : dp_lit;
    an_d  = ACTIVE_LOW_AN ? ~an_lit : an_lit;
  end

  // State and output registers, async active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      idx_q  <= '0;
      tick_q <= 1'b0;
      seg_q  <= SegOff;
      dp_q   <= DpOff;
      an_q   <= AnOff;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      tick_q <= tick_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: three instances (4-digit active-low, 4-digit active-high with
// leading-zero suppression, 1-digit), a per-cycle scoreboard for the 4-digit instances,
// table-driven vectors and hand sequences for reset, enable and single-digit behaviour.
module tb_seven_seg_scan;

  localparam int CD_A = 4;
  localparam int CD_B = 2;
  localparam int CD_C = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 4 digits, active-low seg/an, no LZ.
  logic        rst_a, en_a;
  logic [15:0] val_a;
  logic [3:0]  dpi_a, bl_a, an_a;
  logic [6:0]  seg_a;
  logic        dp_a, tick_a;
  logic [1:0]  idx_a;

  // Instance B: 4 digits, active-high seg/an, LZ on.
  logic        rst_b, en_b;
  logic [15:0] val_b;
  logic [3:0]  dpi_b, bl_b, an_b;
  logic [6:0]  seg_b;
  logic        dp_b, tick_b;
  logic [1:0]  idx_b;

  // Instance C: single digit.
  logic        rst_c, en_c;
  logic [3:0]  val_c;
  logic        dpi_c, bl_c, an_c;
  logic [6:0]  seg_c;
  logic        dp_c, tick_c;
  logic        idx_c;

  seven_seg_scan #(.NUM_DIGITS(4), .CLK_DIV(CD_A), .ACTIVE_LOW_SEG(1'b1),
                   .ACTIVE_LOW_AN(1'b1), .LZ_SUPPRESS(1'b0)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .value(val_a), .dp_in(dpi_a), .blank(bl_a),
    .seg(seg_a), .dp(dp_a), .an(an_a), .digit_idx(idx_a), .frame_tick(tick_a));

  seven_seg_scan #(.NUM_DIGITS(4), .CLK_DIV(CD_B), .ACTIVE_LOW_SEG(1'b0),
                   .ACTIVE_LOW_AN(1'b0), .LZ_SUPPRESS(1'b1)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .value(val_b), .dp_in(dpi_b), .blank(bl_b),
    .seg(seg_b), .dp(dp_b), .an(an_b), .digit_idx(idx_b), .frame_tick(tick_b));

  seven_seg_scan #(.NUM_DIGITS(1), .CLK_DIV(CD_C), .ACTIVE_LOW_SEG(1'b1),
                   .ACTIVE_LOW_AN(1'b1), .LZ_SUPPRESS(1'b0)) u_c (
    .clk(clk), .rst(rst_c), .en(en_c), .value(val_c), .dp_in(dpi_c), .blank(bl_c),
    .seg(seg_c), .dp(dp_c), .an(an_c), .digit_idx(idx_c), .frame_tick(tick_c));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] nib;
    logic [6:0] lit;
  } dec_t;
  dec_t dec_tab[16];

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic [2:0] idx;
    logic       tick;
  } exp_t;

  // Expected registered outputs for a given digit index and inputs (idx/tick filled later).
  function automatic exp_t calc(input int n, input bit als, input bit ala, input bit lz,
                                input int idx, input logic en, input logic [31:0] v,
                                input logic [7:0] dpv, input logic [7:0] bl);
    exp_t e;
    logic dark;
    logic [31:0] upper;
    upper = v >> (4 * idx);
    dark  = !en || bl[idx] || (lz && idx > 0 && upper == 32'h0);
    e.seg = dark ? 7'h00 : dec_tab[v[4*idx +: 4]].lit;
    e.dp  = dark ? 1'b0 : dpv[idx];
    e.an  = dark ? 8'h00 : (8'h01 << idx);
    if (als) begin
      e.seg = ~e.seg;
      e.dp  = ~e.dp;
    end
    if (ala) e.an = ~e.an & ((8'h01 << n) - 8'h01);
    e.idx  = '0;
    e.tick = 1'b0;
    return e;
  endfunction

  // Scoreboard model A: predict at each edge, compare on the next falling edge.
  exp_t q_a[$];
  int   m_div_a, m_idx_a;
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      m_div_a <= 0;
      m_idx_a <= 0;
      q_a.delete();
    end else begin
      exp_t e;
      logic st;
      e      = calc(4, 1'b1, 1'b1, 1'b0, m_idx_a, en_a, 32'(val_a), 8'(dpi_a), 8'(bl_a));
      st     = en_a && (m_div_a == CD_A - 1);
      e.tick = st && (m_idx_a == 3);
      e.idx  = st ? ((m_idx_a == 3) ? 3'd0 : 3'(m_idx_a + 1)) : 3'(m_idx_a);
      if (en_a) m_div_a <= st ? 0 : m_div_a + 1;
      m_idx_a <= int'(e.idx);
      q_a.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst_a) begin
      chk("a.rst.seg", 32'(seg_a), 32'h7F);
      chk("a.rst.an", 32'(an_a), 32'hF);
      chk("a.rst.idx", 32'(idx_a), 32'h0);
    end else if (q_a.size() > 0) begin
      exp_t e;
      e = q_a.pop_front();
      chk("a.sb.seg", 32'(seg_a), 32'(e.seg));
      chk("a.sb.dp", 32'(dp_a), 32'(e.dp));
      chk("a.sb.an", 32'(an_a), 32'(e.an));
      chk("a.sb.idx", 32'(idx_a), 32'(e.idx));
      chk("a.sb.tick", 32'(tick_a), 32'(e.tick));
    end
  end

  // Scoreboard model B; b_show is the digit index the pending prediction was made for.
  exp_t q_b[$];
  int   m_div_b, m_idx_b, b_show;
  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      m_div_b <= 0;
      m_idx_b <= 0;
      b_show  <= 0;
      q_b.delete();
    end else begin
      exp_t e;
      logic st;
      e      = calc(4, 1'b0, 1'b0, 1'b1, m_idx_b, en_b, 32'(val_b), 8'(dpi_b), 8'(bl_b));
      st     = en_b && (m_div_b == CD_B - 1);
      e.tick = st && (m_idx_b == 3);
      e.idx  = st ? ((m_idx_b == 3) ? 3'd0 : 3'(m_idx_b + 1)) : 3'(m_idx_b);
      if (en_b) m_div_b <= st ? 0 : m_div_b + 1;
      b_show  <= m_idx_b;
      m_idx_b <= int'(e.idx);
      q_b.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      chk("b.rst.seg", 32'(seg_b), 32'h00);
      chk("b.rst.an", 32'(an_b), 32'h0);
    end else if (q_b.size() > 0) begin
      exp_t e;
      e = q_b.pop_front();
      chk("b.sb.seg", 32'(seg_b), 32'(e.seg));
      chk("b.sb.dp", 32'(dp_b), 32'(e.dp));
      chk("b.sb.an", 32'(an_b), 32'(e.an));
      chk("b.sb.idx", 32'(idx_b), 32'(e.idx));
      chk("b.sb.tick", 32'(tick_b), 32'(e.tick));
    end
  end

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpv;
    logic [3:0]  bl;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;
  vec_t vt[8];

  typedef struct {
    logic [15:0] val;
    logic [3:0]  lit_mask;
  } lz_t;
  lz_t lz_tab[3];

  int ticks;

  initial begin
    dec_tab[0]  = '{4'h0, 7'b1111110}; dec_tab[1]  = '{4'h1, 7'b0110000};
    dec_tab[2]  = '{4'h2, 7'b1101101}; dec_tab[3]  = '{4'h3, 7'b1111001};
    dec_tab[4]  = '{4'h4, 7'b0110011}; dec_tab[5]  = '{4'h5, 7'b1011011};
    dec_tab[6]  = '{4'h6, 7'b1011111}; dec_tab[7]  = '{4'h7, 7'b1110000};
    dec_tab[8]  = '{4'h8, 7'b1111111}; dec_tab[9]  = '{4'h9, 7'b1111011};
    dec_tab[10] = '{4'hA, 7'b1110111}; dec_tab[11] = '{4'hB, 7'b0011111};
    dec_tab[12] = '{4'hC, 7'b1001110}; dec_tab[13] = '{4'hD, 7'b0111101};
    dec_tab[14] = '{4'hE, 7'b1001111}; dec_tab[15] = '{4'hF, 7'b1000111};
    // Group 0: plain scan of 12AF. Group 1: digit2 blanked, digit0 dp.
    vt[0] = '{16'h12AF, 4'b0000, 4'b0000, 4'hE, 7'b0111000, 1'b1};
    vt[1] = '{16'h12AF, 4'b0000, 4'b0000, 4'hD, 7'b0001000, 1'b1};
    vt[2] = '{16'h12AF, 4'b0000, 4'b0000, 4'hB, 7'b0010010, 1'b1};
    vt[3] = '{16'h12AF, 4'b0000, 4'b0000, 4'h7, 7'b1001111, 1'b1};
    vt[4] = '{16'h12AF, 4'b0001, 4'b0100, 4'hE, 7'b0111000, 1'b0};
    vt[5] = '{16'h12AF, 4'b0001, 4'b0100, 4'hD, 7'b0001000, 1'b1};
    vt[6] = '{16'h12AF, 4'b0001, 4'b0100, 4'hF, 7'b1111111, 1'b1};
    vt[7] = '{16'h12AF, 4'b0001, 4'b0100, 4'h7, 7'b1001111, 1'b1};
    lz_tab[0] = '{16'h0005, 4'b0001};
    lz_tab[1] = '{16'h0000, 4'b0001};
    lz_tab[2] = '{16'h0105, 4'b0111};

    rst_a = 1'b1; en_a = 1'b1; val_a = 16'h12AF; dpi_a = '0; bl_a = '0;
    rst_b = 1'b1; en_b = 1'b1; val_b = 16'h0000; dpi_b = '0; bl_b = '0;
    rst_c = 1'b1; en_c = 1'b1; val_c = 4'h0;     dpi_c = 1'b0; bl_c = 1'b0;
    repeat (2) @(negedge clk);
    chk("a.reset.dp", 32'(dp_a), 32'h1);
    chk("a.reset.tick", 32'(tick_a), 32'h0);

    // Table-driven scan: one full 16-cycle frame per group.
    for (int g = 0; g < 2; g++) begin
      #1;
      rst_a = 1'b1;
      val_a = vt[4*g].val; dpi_a = vt[4*g].dpv; bl_a = vt[4*g].bl;
      @(negedge clk);
      #1 rst_a = 1'b0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        chk("a.vec.an", 32'(an_a), 32'(vt[4*g + k/4].an));
        chk("a.vec.seg", 32'(seg_a), 32'(vt[4*g + k/4].seg));
        chk("a.vec.dp", 32'(dp_a), 32'(vt[4*g + k/4].dp));
        chk("a.vec.tick", 32'(tick_a), 32'(k == 15));
      end
    end

    // Reset mid-scan takes effect without waiting for a clock edge.
    repeat (5) @(negedge clk);
    #1 rst_a = 1'b1;
    #1;
    chk("a.midrst.seg", 32'(seg_a), 32'h7F);
    chk("a.midrst.dp", 32'(dp_a), 32'h1);
    chk("a.midrst.an", 32'(an_a), 32'hF);
    chk("a.midrst.idx", 32'(idx_a), 32'h0);
    chk("a.midrst.tick", 32'(tick_a), 32'h0);
    @(negedge clk);
    #1;
    dpi_a = '0; bl_a = '0; rst_a = 1'b0;

    // Enable pause in the middle of digit2, then resume with the held count.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("a.post.an", 32'(an_a), 32'(vt[k/4].an));
    end
    #1 en_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("a.pause.an", 32'(an_a), 32'hF);
      chk("a.pause.idx", 32'(idx_a), 32'h2);
      chk("a.pause.tick", 32'(tick_a), 32'h0);
    end
    #1 en_a = 1'b1;
    @(negedge clk);
    chk("a.resume0.an", 32'(an_a), 32'hB);
    chk("a.resume0.idx", 32'(idx_a), 32'h2);
    @(negedge clk);
    chk("a.resume1.an", 32'(an_a), 32'hB);
    chk("a.resume1.idx", 32'(idx_a), 32'h3);
    @(negedge clk);
    chk("a.resume2.an", 32'(an_a), 32'h7);
    chk("a.resume2.tick", 32'(tick_a), 32'h0);

    // Instance B: decode sweep on digit0 (upper digits suppressed), then LZ cases.
    #1 rst_b = 1'b0;
    for (int n = 0; n < 16; n++) begin
      #1 val_b = {12'h000, dec_tab[n].nib};
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (b_show == 0) begin
          chk("b.dec.seg", 32'(seg_b), 32'(dec_tab[n].lit));
          chk("b.dec.an", 32'(an_b), 32'h1);
        end
      end
    end
    for (int t = 0; t < 3; t++) begin
      #1 val_b = lz_tab[t].val;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        chk("b.lz.an", 32'(an_b),
            lz_tab[t].lit_mask[b_show] ? (32'h1 << b_show) : 32'h0);
      end
    end

    // Instance C: single digit never moves, ticks every CD_C cycles.
    #1 rst_c = 1'b0;
    ticks = 0;
    for (int c = 0; c < 10 * CD_C; c++) begin
      @(negedge clk);
      chk("c.idx", 32'(idx_c), 32'h0);
      if (tick_c) ticks++;
    end
    chk("c.ticks", 32'(ticks), 32'd10);
    chk("c.an", 32'(an_c), 32'h0);
    chk("c.seg", 32'(seg_c), 32'h01);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
